// File: rtl/tt_adder_pkg.sv
// Shared types and constants for the TinyTapeout 8-bit adder project.
package tt_adder_pkg;
  localparam int WIDTH = 8;
  typedef logic [WIDTH-1:0] operand_t;
  // All uio pins are operand B inputs, so the output enables stay low.
  localparam operand_t UIO_OE_INPUTS = 8'h00;
  localparam operand_t UIO_OUT_TIE   = 8'h00;
endpackage

// File: rtl/adder_rca.sv
// WIDTH-bit ripple-carry adder built from a generate loop of full-adder bit slices.
module adder_rca #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  // c[i] is the carry into bit i; c[WIDTH] is the carry out of the chain.
  logic [WIDTH:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    logic p;
    assign p        = a[i] ^ b[i];
    assign sum[i]   = p ^ c[i];
    assign c[i+1]   = (a[i] & b[i]) | (c[i] & p);
  end

  assign cout = c[WIDTH];
endmodule

// File: rtl/tt_um_project_adder.sv
// TinyTapeout user top: uo_out = (ui_in + uio_in) mod 256.
// Optional macro SUM_REG_EN: registers the sum on clk with async active-low reset.
// Without it the path is purely combinational and the design has no flops.
module tt_um_project_adder
  import tt_adder_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);
  operand_t sum;
  logic     cout;

  adder_rca #(.WIDTH(WIDTH)) u_add (
    .a    (ui_in),
    .b    (uio_in),
    .cin  (1'b0),
    .sum  (sum),
    .cout (cout)
  );

`ifdef SUM_REG_EN
  operand_t sum_q;

  // Capture the sum every cycle; reset clears it without waiting for a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sum_q <= '0;
    else        sum_q <= sum;
  end

  assign uo_out = sum_q;

  // ena and the final carry have no function; fold them away for lint.
  logic unused_ok;
  assign unused_ok = &{1'b0, ena, cout};
`else
  assign uo_out = sum;

  // Clock, reset, ena and the final carry have no function in this build.
  logic unused_ok;
  assign unused_ok = &{1'b0, ena, clk, rst_n, cout};
`endif

  assign uio_out = UIO_OUT_TIE;
  assign uio_oe  = UIO_OE_INPUTS;
endmodule

// File: tb/tb_tt_um_project_adder.sv
// Table-driven bench for tt_um_project_adder; covers both the default and SUM_REG_EN builds.
module tb_tt_um_project_adder;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      name;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs [8];

  tt_um_project_adder dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
    end
  endtask

  // Apply one operand pair and wait until uo_out should reflect it.
  task automatic apply(input logic [7:0] a, input logic [7:0] b);
`ifdef SUM_REG_EN
    @(negedge clk);
    ui_in  = a;
    uio_in = b;
    @(posedge clk);
    #1;
`else
    ui_in  = a;
    uio_in = b;
    #1;
`endif
  endtask

  initial begin
    vecs[0] = '{"1p1",      8'h01, 8'h01, 8'h02};
    vecs[1] = '{"nibble",   8'h0F, 8'h01, 8'h10};
    vecs[2] = '{"wrap",     8'hFF, 8'h01, 8'h00};
    vecs[3] = '{"ff_ff",    8'hFF, 8'hFF, 8'hFE};
    vecs[4] = '{"nocarry",  8'hAA, 8'h55, 8'hFF};
    vecs[5] = '{"zero",     8'h00, 8'h00, 8'h00};
    vecs[6] = '{"msb",      8'h80, 8'h80, 8'h00};
    vecs[7] = '{"mixed",    8'h3C, 8'h47, 8'h83};

    ena    = 1'b1;
    ui_in  = 8'h00;
    uio_in = 8'h00;
    rst_n  = 1'b0;
    #2;
    check("rst_uo",     uo_out,  8'h00);
    check("rst_uio_out", uio_out, 8'h00);
    check("rst_uio_oe",  uio_oe,  8'h00);

`ifdef SUM_REG_EN
    // Reset is asynchronous: the output clears with no clock edge.
    ui_in  = 8'h0F;
    uio_in = 8'h01;
    @(posedge clk);
    #1;
    check("rst_hold", uo_out, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("pre_edge", uo_out, 8'h00);
    @(posedge clk);
    #1;
    check("one_edge", uo_out, 8'h10);
`else
    rst_n = 1'b1;
`endif

    foreach (vecs[i]) begin
      apply(vecs[i].a, vecs[i].b);
      check(vecs[i].name, uo_out, vecs[i].exp);
      check({vecs[i].name, "_oe"},  uio_oe,  8'h00);
      check({vecs[i].name, "_out"}, uio_out, 8'h00);
    end

`ifdef SUM_REG_EN
    // New operands appear only after the next rising edge.
    apply(8'h0F, 8'h01);
    @(negedge clk);
    ui_in  = 8'h01;
    uio_in = 8'h01;
    #1;
    check("latency_hold", uo_out, 8'h10);
    @(posedge clk);
    #1;
    check("latency_load", uo_out, 8'h02);
    // Mid-stream reset clears the register between edges.
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst", uo_out, 8'h00);
    check("mid_rst_oe", uio_oe, 8'h00);
    @(posedge clk);
    #1;
    check("mid_rst_hold", uo_out, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst", uo_out, 8'h02);
`else
    // Output is independent of ena, rst_n and clk.
    apply(8'h0F, 8'h01);
    ena = 1'b0;
    #1;
    check("ena_lo", uo_out, 8'h10);
    rst_n = 1'b0;
    #1;
    check("rst_lo", uo_out, 8'h10);
    check("rst_lo_oe", uio_oe, 8'h00);
    @(posedge clk);
    #1;
    check("clk_edge", uo_out, 8'h10);
    ena   = 1'b1;
    rst_n = 1'b1;
    #1;
    check("restore", uo_out, 8'h10);
    apply(8'hC8, 8'h64);
    check("c8_64", uo_out, 8'h2C);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/tt_um_project_adder.md
Name: tt_um_project_adder

Overview:
- TinyTapeout user-project top for an 8-bit unsigned adder.
- Operand A comes in on the dedicated inputs `ui_in`; operand B comes in on the bidirectional pins `uio_in`, which are configured as inputs only.
- The 8-bit sum, truncated modulo 256, drives the dedicated outputs `uo_out`.
- Sits directly under the TinyTapeout harness. It has no other submodules beyond its own adder datapath.

Parameters:
- WIDTH, 8, operand and sum width. Fixed by the TinyTapeout pinout; never overridden.

Ports:
- clk      input   1  system clock. Used only when SUM_REG_EN is defined.
- rst_n    input   1  asynchronous active-low reset.
- ena      input   1  design-selected indication from the harness. Ignored functionally.
- ui_in    input   8  operand A, unsigned.
- uio_in   input   8  operand B, unsigned.
- uo_out   output  8  sum A+B modulo 256.
- uio_out  output  8  tied to 8'h00.
- uio_oe   output  8  tied to 8'h00, so all uio pins are inputs.

Behaviour:
- Default build (macro undefined): purely combinational path.
  - uo_out = (ui_in + uio_in)[7:0].
  - The result is valid within the same delta/settle time; zero clock latency.
- Wrap-around: the carry-out (bit 8) is discarded.
  - 0xFF + 0x01 gives 0x00.
  - 0xFF + 0xFF gives 0xFE.
  - No saturation; no overflow flag on any pin.
- uio_out and uio_oe are constant 8'h00 in every mode, including during reset.
- The output must not depend on ena, clk or rst_n in the default build.
- Adder structure: ripple-carry chain of WIDTH full adders.
  - Full adder: sum = a^b^cin; cout = (a&b) | (cin&(a^b)).
  - Carry-in to bit 0 is 0.
  - Any synthesizable equivalent is acceptable, provided results are bit-exact.
- Unused inputs (ena, clk/rst_n when macro undefined, final carry-out) are consumed in a dummy reduction wire to keep lint clean. They have no functional effect.
- There are no X states: all outputs are driven for any input combination.

Optional Feature:
- Macro SUM_REG_EN.
  - Defined: the sum is captured in an 8-bit register on the rising edge of clk, and uo_out is the register output.
    - Latency is 1 cycle from operand change to uo_out.
    - Asynchronous reset: rst_n = 0 forces uo_out = 8'h00 immediately, independent of clk.
    - Reset released: the first rising edge loads the current sum.
    - Reset asserted mid-operation clears the register immediately; the sum in flight is lost.
    - The register updates every cycle; ena is still ignored.
  - Undefined: combinational behaviour as above; no flops in the design.

Decomposition:
- Package tt_adder_pkg:
  - localparam WIDTH = 8.
  - typedef logic [WIDTH-1:0] operand_t.
  - UIO_OE_INPUTS = 8'h00.
- One natural sub-module: adder_rca.
  - WIDTH-bit ripple-carry adder with inputs a, b, cin and outputs sum, cout.
  - Internally a generate loop of full-adder bit slices.
- The top instantiates adder_rca with cin = 0. It holds the optional output register and the pin tie-offs.

Test Plan:
- ui_in=0x01, uio_in=0x01 -> uo_out=0x02; uio_oe=0x00; uio_out=0x00.
- ui_in=0x0F, uio_in=0x01 -> uo_out=0x10 (carry ripple across the nibble boundary).
- ui_in=0xFF, uio_in=0x01 -> uo_out=0x00 (full-chain carry, wrap-around); also 0xFF+0xFF -> 0xFE.
- ui_in=0xAA, uio_in=0x55 -> uo_out=0xFF (no carries); also 0x00+0x00 -> 0x00.
- Toggle ena and rst_n while holding 0x0F+0x01 -> uo_out stays 0x10 (default build).
- SUM_REG_EN defined:
  - rst_n=0 -> uo_out=0x00 asynchronously.
  - Release reset, apply 0x0F+0x01 -> uo_out=0x10 after exactly one rising edge.
  - Assert rst_n=0 mid-stream -> uo_out=0x00 without a clock edge.
